// File: rtl/mchan_capture_pkg.sv
// mchan_capture_pkg
// Shared definitions for the multi-channel capture block:
//   - state_t   : capture state machine encoding
//   - MAX_NCH   : largest supported channel count
//   - MAX_DEC   : largest decimation exponent honoured (larger requests clamp)
//   - clamp_dec : saturates a requested decimation exponent to MAX_DEC
package mchan_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int MAX_NCH = 8;
  localparam int MAX_DEC = 10;

  function automatic logic [3:0] clamp_dec(input logic [3:0] dec_req);
    return (dec_req > 4'(MAX_DEC)) ? 4'(MAX_DEC) : dec_req;
  endfunction

endpackage

// File: rtl/mchan_capture_trig.sv
// trig_detect
// Selects one asynchronous trigger line, brings it into the clk domain
// through a two-flop synchroniser and produces a one-cycle pulse on the
// chosen edge.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   trig       : asynchronous trigger lines, one per channel
//   trig_src   : index of the line to watch (>= NCH selects nothing)
//   trig_edge  : 0 = rising edge, 1 = falling edge
//   trig_hit   : one-cycle pulse when the selected edge is seen
module trig_detect #(
  parameter int NCH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] trig,
  input  logic [2:0]     trig_src,
  input  logic           trig_edge,
  output logic           trig_hit
);

  logic [NCH-1:0] sel_vec;
  logic           sel_raw;
  logic           sync_1;
  logic           sync_2;
  logic           sync_prev;

  // One-hot style select: an out-of-range index matches no line, so the
  // selected signal stays 0 and can never produce an edge.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
      assign sel_vec[gi] = trig[gi] & (trig_src == 3'(gi));
    end
  endgenerate

  assign sel_raw = |sel_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= sel_raw;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign trig_hit = trig_edge ? (~sync_2 & sync_prev) : (sync_2 & ~sync_prev);

endmodule

// File: rtl/mchan_capture.sv
// mchan_capture
// Multi-channel logic-analyser style capture controller. Writes samples
// into a circular RAM (DEPTH = 2^AW) shared by NCH channels, keeps
// DEPTH - trig_pos pre-trigger samples, then trig_pos post-trigger samples.
// Outside a capture the RAM port is handed to the host read interface.
// Optional feature: define MCHAN_CAPTURE_DECIM_EN to add the 'dec' input,
// which takes one sample every 2^dec adc_clk periods (dec clamps at 10).
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   adc_clk       : ADC sample clock (clk/2)
//   trig          : asynchronous trigger inputs
//   trig_src      : trigger channel index
//   trig_edge     : 0 rising, 1 falling
//   trig_pos      : number of post-trigger samples (0 = trigger ends capture)
//   ch_en         : per-channel write enable mask
//   arm, stop     : start / force end of a capture (arm wins over stop)
//   rd_en, rd_addr: host read port, routed to the RAM in IDLE/DONE
//   dec           : decimation exponent (MCHAN_CAPTURE_DECIM_EN only)
//   en, we, addr  : RAM enable, per-channel write enables, shared address
//   triggered     : trigger accepted in the current capture
//   capture_done  : high while in DONE
//   trace_end     : address of the last written sample
module mchan_capture
  import mchan_capture_pkg::*;
#(
  parameter int NCH = 3,
  parameter int AW  = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           adc_clk,
  input  logic [NCH-1:0] trig,
  input  logic [2:0]     trig_src,
  input  logic           trig_edge,
  input  logic [AW-1:0]  trig_pos,
  input  logic [NCH-1:0] ch_en,
  input  logic           arm,
  input  logic           stop,
  input  logic           rd_en,
  input  logic [AW-1:0]  rd_addr,
`ifdef MCHAN_CAPTURE_DECIM_EN
  input  logic [3:0]     dec,
`endif
  output logic           en,
  output logic [NCH-1:0] we,
  output logic [AW-1:0]  addr,
  output logic           triggered,
  output logic           capture_done,
  output logic [AW-1:0]  trace_end
);

  localparam int DEPTH = 1 << AW;

  state_t         state;
  state_t         state_next;
  logic           adc_clk_reg;
  logic [AW-1:0]  wptr;
  logic [AW:0]    pre_cnt;
  logic [AW:0]    pre_thresh;
  logic [AW-1:0]  post_cnt;
  logic           triggered_reg;
  logic [AW-1:0]  trace_end_reg;
  logic           slot;
  logic           capturing;
  logic           wr_slot;
  logic           trig_hit;

  trig_detect #(.NCH(NCH)) u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .trig_src  (trig_src),
    .trig_edge (trig_edge),
    .trig_hit  (trig_hit)
  );

  // ---------------------------------------------------------------------
  // Sample slot generation
  // ---------------------------------------------------------------------
`ifdef MCHAN_CAPTURE_DECIM_EN
  localparam int DW = MAX_DEC + 1;
  logic [DW-1:0] dec_cnt;
  logic [DW-1:0] dec_limit;
  logic [3:0]    dec_eff;

  assign dec_eff   = clamp_dec(dec);
  assign dec_limit = (DW'(1) << dec_eff) - DW'(1);
  // Counts adc_clk high cycles from arm; the first high cycle after arm
  // is a slot, then every 2^dec-th one.
  assign slot      = adc_clk_reg & (dec_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (arm) begin
      dec_cnt <= '0;
    end else if (adc_clk_reg) begin
      dec_cnt <= (dec_cnt >= dec_limit) ? '0 : dec_cnt + DW'(1);
    end
  end
`else
  assign slot = adc_clk_reg;
`endif

  assign capturing = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
  // The arm cycle restarts the capture, so its slot is not written; the
  // reset term keeps an in-flight capture from writing while rst_n is low.
  assign wr_slot   = capturing & slot & ~arm & rst_n;

  // trig_pos = 0 means the whole buffer is pre-trigger history.
  assign pre_thresh = (trig_pos == '0) ? (AW+1)'(DEPTH)
                                       : (AW+1)'(DEPTH) - (AW+1)'(trig_pos);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (arm) begin
      state_next = ST_PRE;
    end else begin
      case (state)
        ST_PRE: begin
          if (stop) begin
            state_next = ST_DONE;
          end else if (wr_slot && (pre_cnt + (AW+1)'(1) == pre_thresh)) begin
            state_next = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            state_next = ST_DONE;
          end else if (trig_hit) begin
            state_next = (trig_pos == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          // Leave after the write that exhausts the post counter.
          if (stop || (wr_slot && post_cnt == AW'(1))) begin
            state_next = ST_DONE;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (RAM port mux between capture and host read)
  // ---------------------------------------------------------------------
  always_comb begin
    en   = 1'b0;
    we   = '0;
    addr = wptr;
    if (!capturing) begin
      en   = rd_en;
      addr = rd_addr;
    end else if (wr_slot) begin
      en = 1'b1;
      we = ch_en;
    end
  end

  assign capture_done = (state == ST_DONE);
  assign triggered    = triggered_reg;
  assign trace_end    = trace_end_reg;
  assign adc_clk      = adc_clk_reg;

  // ---------------------------------------------------------------------
  // Datapath: pointers, counters, trigger flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_clk_reg   <= 1'b0;
      wptr          <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
      triggered_reg <= 1'b0;
      trace_end_reg <= '0;
    end else begin
      adc_clk_reg <= ~adc_clk_reg;
      if (arm) begin
        wptr          <= '0;
        pre_cnt       <= '0;
        triggered_reg <= 1'b0;
      end else begin
        if (wr_slot) begin
          wptr          <= wptr + AW'(1);
          trace_end_reg <= wptr;
          if (state == ST_PRE) begin
            pre_cnt <= pre_cnt + (AW+1)'(1);
          end
          if (state == ST_POST) begin
            post_cnt <= post_cnt - AW'(1);
          end
        end
        // A stop in the same cycle ends the capture with triggered unchanged.
        if ((state == ST_ARMED) && trig_hit && !stop) begin
          triggered_reg <= 1'b1;
          post_cnt      <= trig_pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_mchan_capture.sv
module tb_mchan_capture;
  localparam int NCH   = 3;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           adc_clk;
  logic [NCH-1:0] trig;
  logic [2:0]     trig_src;
  logic           trig_edge;
  logic [AW-1:0]  trig_pos;
  logic [NCH-1:0] ch_en;
  logic           arm;
  logic           stop;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
`ifdef MCHAN_CAPTURE_DECIM_EN
  logic [3:0]     dec;
`endif
  logic           en;
  logic [NCH-1:0] we;
  logic [AW-1:0]  addr;
  logic           triggered;
  logic           capture_done;
  logic [AW-1:0]  trace_end;

  always #5 clk = ~clk;

  mchan_capture #(.NCH(NCH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_clk      (adc_clk),
    .trig         (trig),
    .trig_src     (trig_src),
    .trig_edge    (trig_edge),
    .trig_pos     (trig_pos),
    .ch_en        (ch_en),
    .arm          (arm),
    .stop         (stop),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
`ifdef MCHAN_CAPTURE_DECIM_EN
    .dec          (dec),
`endif
    .en           (en),
    .we           (we),
    .addr         (addr),
    .triggered    (triggered),
    .capture_done (capture_done),
    .trace_end    (trace_end)
  );

  // Expected result of one finished capture
  typedef struct {
    int te;
    int trg;
    int post;
    int total;
    int we1;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic push_exp(input int te, input int trg, input int post,
                          input int total, input int we1);
    exp_t e;
    e.te = te; e.trg = trg; e.post = post; e.total = total; e.we1 = we1;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int   wr_cnt = 0;
  int   post_wr = 0;
  int   exp_addr = 0;
  int   addr_bad = 0;
  int   gap_bad = 0;
  int   exp_gap = 2;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   we1_seen = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (capture_done === 1'b0 && en === 1'b1 && rd_en === 1'b0) begin
      if (int'(addr) != exp_addr) addr_bad++;
      if (wr_cnt > 0 && (cyc - last_wr_cyc) != exp_gap) gap_bad++;
      last_wr_cyc = cyc;
      exp_addr    = (exp_addr + 1) % DEPTH;
      wr_cnt++;
      if (triggered === 1'b1) post_wr++;
      if (we[1] === 1'b1) we1_seen = 1;
    end
    if (capture_done === 1'b1 && prev_done == 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("done: trace_end=%0d triggered=%0d post=%0d writes=%0d we1=%0d",
                 trace_end, triggered, post_wr, wr_cnt, we1_seen);
        check("trace_end", int'(trace_end), e.te);
        check("triggered", int'(triggered), e.trg);
        check("post_writes", post_wr, e.post);
        check("total_writes", wr_cnt, e.total);
        check("we1_seen", we1_seen, e.we1);
        check("addr_sequence_errors", addr_bad, 0);
        check("write_gap_errors", gap_bad, 0);
      end
    end
    prev_done = (capture_done === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic with_stop);
    @(posedge clk);
    #1;
    arm = 1'b1; stop = with_stop;
    wr_cnt = 0; post_wr = 0; exp_addr = 0; addr_bad = 0; gap_bad = 0; we1_seen = 0;
    @(posedge clk);
    #1;
    arm = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_cnt < n && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (wr_cnt < n) check("write_count_timeout", wr_cnt, n);
    #1;
  endtask

  task automatic wait_post(input int n);
    int k = 0;
    while (post_wr < n && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (post_wr < n) check("post_count_timeout", post_wr, n);
    #1;
  endtask

  task automatic wait_done();
    int k = 0;
    while (capture_done !== 1'b1 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (capture_done !== 1'b1) check("done_timeout", 0, 1);
    repeat (2) tick();
  endtask

  task automatic host_read_check();
    @(posedge clk);
    #1;
    rd_en = 1'b1; rd_addr = 9'd37;
    @(negedge clk);
    $display("host read: addr=%0d en=%0d we=%0d", addr, en, we);
    check("rd_addr_passthrough", int'(addr), 37);
    check("rd_en_passthrough", int'(en), 1);
    check("rd_we_zero", int'(we), 0);
    check("done_held", int'(capture_done), 1);
    tick();
    rd_en = 1'b0; rd_addr = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a0;
    rst_n = 1'b0; trig = '0; trig_src = 3'd0; trig_edge = 1'b0;
    trig_pos = 9'd100; ch_en = 3'b111; arm = 1'b0; stop = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
`ifdef MCHAN_CAPTURE_DECIM_EN
    dec = 4'd0;
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_adc_clk", int'(adc_clk), 0);
    check("rst_triggered", int'(triggered), 0);
    check("rst_capture_done", int'(capture_done), 0);
    check("rst_trace_end", int'(trace_end), 0);
    check("rst_we", int'(we), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    a0 = adc_clk;
    @(negedge clk);
    check("adc_clk_toggle", int'(adc_clk), int'(!a0));

    // 1: trigger after 600 slots, 100 post-trigger writes
    do_arm(1'b0);
    wait_wr(600);
    trig[0] = 1'b1;
    push_exp(188, 1, 100, 701, 1);
    wait_done();
    trig = '0;

    // 2: early edge in PRE ignored, later edge accepted
    do_arm(1'b0);
    wait_wr(200);
    trig[0] = 1'b1;
    repeat (6) tick();
    trig[0] = 1'b0;
    wait_wr(300);
    check("pre_edge_ignored", int'(triggered), 0);
    wait_wr(450);
    trig[0] = 1'b1;
    push_exp(38, 1, 100, 551, 1);
    wait_done();
    trig = '0;

    // 3: trig_pos = 0 ends the capture on the trigger
    trig_pos = 9'd0;
    do_arm(1'b0);
    wait_wr(520);
    trig[0] = 1'b1;
    push_exp(8, 1, 0, 521, 1);
    wait_done();
    trig = '0;
    trig_pos = 9'd100;

    // 4: arm + stop together in POST restarts, later stop alone ends
    do_arm(1'b0);
    wait_wr(450);
    trig[0] = 1'b1;
    wait_post(50);
    trig = '0;
    do_arm(1'b1);
    repeat (10) tick();
    check("restart_done_low", int'(capture_done), 0);
    check("restart_trig_low", int'(triggered), 0);
    wait_wr(100);
    stop = 1'b1;
    push_exp(99, 0, 0, 100, 1);
    tick();
    stop = 1'b0;
    wait_done();
    host_read_check();

    // 5: channel 1 masked, address sequence unchanged
    ch_en = 3'b101;
    do_arm(1'b0);
    wait_wr(450);
    trig[0] = 1'b1;
    push_exp(38, 1, 100, 551, 0);
    wait_done();
    trig = '0;
    ch_en = 3'b111;

`ifdef MCHAN_CAPTURE_DECIM_EN
    // 6: dec = 2, one write per 4 adc_clk periods
    dec = 4'd2;
    exp_gap = 8;
    do_arm(1'b0);
    wait_wr(20);
    stop = 1'b1;
    push_exp(19, 0, 0, 20, 1);
    tick();
    stop = 1'b0;
    wait_done();
    host_read_check();
    dec = 4'd0;
    exp_gap = 2;
`endif

    // 7: reset mid-capture aborts with no further writes
    do_arm(1'b0);
    wait_wr(30);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("reset_abort_writes", wr_cnt, 30);
    check("reset_abort_done", int'(capture_done), 0);
    check("reset_abort_trace_end", int'(trace_end), 0);
    check("reset_abort_triggered", int'(triggered), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
